ni_flit_packetizer: RTL and testbench
=====================================

Name: ni_flit_packetizer

Overview:
- Parametrised request-side packetizer for the network interface.
- Accepts one DATA_WIDTH transaction with routing fields through a valid/ready handshake, registers it, and serialises it into one head flit followed by data flits (body, then tail) onto a FLIT_WIDTH link with valid/ready backpressure.
- Generalises the fixed 16-bit, 32-bit-data flit format to arbitrary data, flit and address widths.
- Supports back-to-back packets with no idle gap between them.

Parameters:
- DATA_WIDTH, 32: transaction payload width.
- FLIT_WIDTH, 16: link flit width. Payload bits per data flit P = FLIT_WIDTH-1.
- ADDR_WIDTH, 4: width of source and destination node address.
- NUM_DATA_FLITS, ceil(DATA_WIDTH/P) (derived, localparam): body flits plus tail flit.
- TOTAL_FLITS, NUM_DATA_FLITS+1 (derived): head flit plus data flits.
- CNT_WIDTH, 3: width of the head-flit flit-count field. Elaboration error if TOTAL_FLITS > 2^CNT_WIDTH-1, or if CNT_WIDTH+5+2*ADDR_WIDTH > FLIT_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pkt_valid_i  in  1  transaction valid
- pkt_ready_o  out  1  packetizer can accept a transaction
- pkt_data_i  in  DATA_WIDTH  payload
- pkt_dest_i  in  ADDR_WIDTH  destination node
- pkt_src_i  in  ADDR_WIDTH  source node
- pkt_mode_i  in  3  mode bits
- pkt_flag_i  in  2  flag bits
- flit_valid_o  out  1  flit valid
- flit_ready_i  in  1  downstream accepts flit
- flit_o  out  FLIT_WIDTH  flit
- busy_o  out  1  packet in flight (state != IDLE)

Behaviour:
- Reset values: state=IDLE, flit_valid_o=0, flit_o=0, busy_o=0, beat counter=0, capture registers=0. pkt_ready_o=1 in IDLE.
- FSM states: IDLE, HEAD, DATA.
- IDLE: pkt_ready_o=1. When pkt_valid_i is high, capture all pkt_* fields and go to HEAD.
- Latency: the head flit is valid on the cycle after acceptance.
- HEAD: flit_valid_o=1 and flit_o is the head flit, MSB-first:
  - {TOTAL_FLITS[CNT_WIDTH-1:0], flag, mode, dest, src}, zero-padded in the MSBs up to FLIT_WIDTH.
  - On flit_ready_i, set beat=0 and go to DATA.
- DATA: flit_o = {payload_k, id}.
  - payload_k = captured_data[k*P +: P]; bits beyond DATA_WIDTH are zero.
  - id=0 for beats 0..NUM_DATA_FLITS-2 (body); id=1 for beat NUM_DATA_FLITS-1 (tail).
  - On flit_ready_i the beat increments.
  - On the tail handshake, return to IDLE.
- Back-to-back: in DATA on the tail beat, pkt_ready_o = flit_ready_i (combinational path).
  - If pkt_valid_i is also high, capture the new transaction and go directly to HEAD, with no bubble.
  - In every other state and beat, pkt_ready_o=0.
- Flit stability: flit_valid_o and flit_o stay stable while flit_valid_o=1 and flit_ready_i=0. Held data is never altered.
- Single data flit case (NUM_DATA_FLITS=1): the single data flit is the tail, id=1.
- Reset mid-packet: immediately returns to IDLE and drops the partial packet. flit_valid_o deasserts asynchronously.
- The beat counter is sized $clog2(NUM_DATA_FLITS)+1 and never wraps past NUM_DATA_FLITS-1.

Optional Feature:
- Macro: NI_FLIT_PARITY_EN.
- When defined:
  - Adds port flit_par_o (out, 1) = XOR reduction of flit_o (even parity), valid whenever flit_valid_o=1.
  - flit_par_o is registered alongside flit_o and resets to 0.
- When undefined: the port and its logic are absent, with no other behavioural change.

Test Plan:
- Defaults; accept data=0xDEADBEEF, dest=5, src=0xA, mode=3'b010, flag=2'b01 with flit_ready_i=1 -> flits 0x8A5A, 0x7DDE, 0x7AB6, 0x0007 on 4 consecutive cycles starting 1 cycle after acceptance; busy_o drops after the tail.
- Same packet with flit_ready_i low for 3 cycles during the first body flit -> 0x7DDE held stable for 3 cycles, no flit lost or duplicated.
- Two packets presented back-to-back (second data=0x00000001) -> second head 0x8A5A follows the tail 0x0007 in the very next cycle; second packet flits 0x0002, 0x0000, 0x0001.
- Assert rst during the second flit -> flit_valid_o=0 in the same cycle, pkt_ready_o=1, and the next packet starts with a head flit.
- DATA_WIDTH=8, FLIT_WIDTH=16 -> TOTAL_FLITS=2; data=0xFF yields head count=2 followed by a single tail flit 0x01FF.
- With NI_FLIT_PARITY_EN: head 0x8A5A -> flit_par_o=1; tail 0x0007 -> flit_par_o=1; flit 0x7DDE -> flit_par_o=0.

Source files
------------

// File: rtl/ni_flit_packetizer.sv
// -----------------------------------------------------------------------------
// ni_flit_packetizer
//
// Request-side packetizer for the network interface. One transaction (payload
// plus routing fields) is accepted through a valid/ready handshake and is
// serialised onto a FLIT_WIDTH link as:
//   - one head flit : {flit count, flag, mode, dest, src}, zero-padded in the MSBs
//   - NUM_DATA_FLITS data flits : {payload slice, id}
//     (id=0 for body flits, id=1 for the tail flit)
// Packets may follow each other with no idle cycle: a new transaction is
// accepted in the same cycle as the tail handshake.
//
// Optional feature (macro NI_FLIT_PARITY_EN):
//   Adds flit_par_o, the even parity (XOR reduction) of flit_o. It is
//   registered alongside flit_o.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pkt_valid_i   transaction valid
//   pkt_ready_o   packetizer can accept a transaction (combinational)
//   pkt_data_i    payload, DATA_WIDTH bits
//   pkt_dest_i    destination node address
//   pkt_src_i     source node address
//   pkt_mode_i    3 mode bits
//   pkt_flag_i    2 flag bits
//   flit_valid_o  flit valid (registered)
//   flit_ready_i  downstream accepts the flit
//   flit_o        flit, FLIT_WIDTH bits (registered)
//   flit_par_o    even parity of flit_o (only with NI_FLIT_PARITY_EN)
//   busy_o        a packet is in flight
// -----------------------------------------------------------------------------
module ni_flit_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int FLIT_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [DATA_WIDTH-1:0] pkt_data_i,
  input  logic [ADDR_WIDTH-1:0] pkt_dest_i,
  input  logic [ADDR_WIDTH-1:0] pkt_src_i,
  input  logic [2:0]            pkt_mode_i,
  input  logic [1:0]            pkt_flag_i,
  output logic                  flit_valid_o,
  input  logic                  flit_ready_i,
  output logic [FLIT_WIDTH-1:0] flit_o,
`ifdef NI_FLIT_PARITY_EN
  output logic                  flit_par_o,
`endif
  output logic                  busy_o
);

  // Payload bits carried by each data flit (one bit is the body/tail id).
  localparam int P              = FLIT_WIDTH - 1;
  localparam int NUM_DATA_FLITS = (DATA_WIDTH + P - 1) / P;
  localparam int TOTAL_FLITS    = NUM_DATA_FLITS + 1;
  localparam int HEAD_BITS      = CNT_WIDTH + 5 + 2 * ADDR_WIDTH;
  localparam int BEAT_W         = $clog2(NUM_DATA_FLITS) + 1;
  // Payload zero-extended to a whole number of flit slices.
  localparam int PAD_W          = NUM_DATA_FLITS * P;

  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(NUM_DATA_FLITS - 1);
  localparam logic [CNT_WIDTH-1:0] TOTAL_CNT = CNT_WIDTH'(TOTAL_FLITS);

  // Parameter sanity checks at elaboration time.
  generate
    if (TOTAL_FLITS > (2 ** CNT_WIDTH) - 1) begin : g_cnt_err
      $error("ni_flit_packetizer: TOTAL_FLITS does not fit in CNT_WIDTH");
    end
    if (HEAD_BITS > FLIT_WIDTH) begin : g_head_err
      $error("ni_flit_packetizer: head flit fields exceed FLIT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  flit_valid_q, flit_valid_d;

  logic [PAD_W-1:0]      data_pad;
  logic [BEAT_W-1:0]     beat_inc;
  logic                  accept;

  assign data_pad = PAD_W'(data_q);
  assign beat_inc = beat_q + BEAT_W'(1);

  // Head flit built straight from the incoming transaction. It is stored in
  // flit_q at acceptance, so the routing fields need no separate registers.
  function automatic logic [FLIT_WIDTH-1:0] head_flit(
    input logic [ADDR_WIDTH-1:0] dest,
    input logic [ADDR_WIDTH-1:0] src,
    input logic [2:0]            mode,
    input logic [1:0]            flag
  );
    logic [FLIT_WIDTH-1:0] f;
    f = '0;
    f[HEAD_BITS-1:0] = {TOTAL_CNT, flag, mode, dest, src};
    return f;
  endfunction

  // Data flit for a given beat: payload slice in the upper bits, id in bit 0.
  function automatic logic [FLIT_WIDTH-1:0] data_flit(
    input logic [PAD_W-1:0]  pad,
    input logic [BEAT_W-1:0] beat
  );
    return {pad[int'(beat) * P +: P], (beat == LAST_BEAT)};
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      data_q       <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      data_q       <= data_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic. flit_q/flit_valid_q only change on a
  // handshake or an acceptance, which keeps a stalled flit stable.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    data_d       = data_q;
    flit_d       = flit_q;
    flit_valid_d = flit_valid_q;
    pkt_ready_o  = 1'b0;
    accept       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pkt_ready_o = 1'b1;
        accept      = pkt_valid_i;
      end

      ST_HEAD: begin
        if (flit_ready_i) begin
          state_d = ST_DATA;
          beat_d  = '0;
          flit_d  = data_flit(data_pad, BEAT_W'(0));
        end
      end

      ST_DATA: begin
        if (beat_q == LAST_BEAT) begin
          // The tail handshake frees the capture registers in this very cycle,
          // so the next transaction may be taken without a bubble.
          pkt_ready_o = flit_ready_i;
          if (flit_ready_i) begin
            state_d      = ST_IDLE;
            beat_d       = '0;
            flit_d       = '0;
            flit_valid_d = 1'b0;
            accept       = pkt_valid_i;
          end
        end else if (flit_ready_i) begin
          beat_d = beat_inc;
          flit_d = data_flit(data_pad, beat_inc);
        end
      end

      default: begin
        state_d      = ST_IDLE;
        beat_d       = '0;
        flit_d       = '0;
        flit_valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      state_d      = ST_HEAD;
      data_d       = pkt_data_i;
      flit_d       = head_flit(pkt_dest_i, pkt_src_i, pkt_mode_i, pkt_flag_i);
      flit_valid_d = 1'b1;
    end
  end

  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign busy_o       = (state_q != ST_IDLE);

`ifdef NI_FLIT_PARITY_EN
  // Parity is computed from the next flit so it lands in the same cycle.
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^flit_d;
    end
  end

  assign flit_par_o = par_q;
`endif

endmodule

// File: tb/tb_ni_flit_packetizer.sv
module tb_ni_flit_packetizer;

  logic        clk;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_data;
  logic [3:0]  pkt_dest;
  logic [3:0]  pkt_src;
  logic [2:0]  pkt_mode;
  logic [1:0]  pkt_flag;
  logic        flit_valid;
  logic        flit_ready;
  logic [15:0] flit;
  logic        busy;

  logic        p8_valid;
  logic        p8_ready;
  logic [7:0]  p8_data;
  logic        f8_valid;
  logic        f8_ready;
  logic [15:0] f8;
  logic        busy8;

`ifdef NI_FLIT_PARITY_EN
  logic        par;
  logic        par8;
`endif

  int tests = 0;
  int fails = 0;

  ni_flit_packetizer u_dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid_i  (pkt_valid),
    .pkt_ready_o  (pkt_ready),
    .pkt_data_i   (pkt_data),
    .pkt_dest_i   (pkt_dest),
    .pkt_src_i    (pkt_src),
    .pkt_mode_i   (pkt_mode),
    .pkt_flag_i   (pkt_flag),
    .flit_valid_o (flit_valid),
    .flit_ready_i (flit_ready),
    .flit_o       (flit),
`ifdef NI_FLIT_PARITY_EN
    .flit_par_o   (par),
`endif
    .busy_o       (busy)
  );

  ni_flit_packetizer #(.DATA_WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid_i  (p8_valid),
    .pkt_ready_o  (p8_ready),
    .pkt_data_i   (p8_data),
    .pkt_dest_i   (pkt_dest),
    .pkt_src_i    (pkt_src),
    .pkt_mode_i   (pkt_mode),
    .pkt_flag_i   (pkt_flag),
    .flit_valid_o (f8_valid),
    .flit_ready_i (f8_ready),
    .flit_o       (f8),
`ifdef NI_FLIT_PARITY_EN
    .flit_par_o   (par8),
`endif
    .busy_o       (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [2:0]  mode;
    logic [1:0]  flag;
    logic [63:0] exp;   // four flits, head first in the MSBs
  } vec_t;

  vec_t vecs [4];

  logic [15:0] sbq [$];
  logic        hold;
  logic [15:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    pkt_data = vecs[i].data;
    pkt_dest = vecs[i].dest;
    pkt_src  = vecs[i].src;
    pkt_mode = vecs[i].mode;
    pkt_flag = vecs[i].flag;
  endtask

  function automatic logic [15:0] vflit(input int i, input int k);
    logic [63:0] e;
    e = vecs[i].exp;
    return e[63 - 16 * k -: 16];
  endfunction

  task automatic chk_flit(input string name, input logic [15:0] exp);
    chk({name, "_valid"}, 64'(flit_valid), 64'd1);
    chk(name, 64'(flit), 64'(exp));
`ifdef NI_FLIT_PARITY_EN
    chk({name, "_par"}, 64'(par), 64'(^exp));
`endif
  endtask

  // One packet with no backpressure, checked flit by flit.
  task automatic run_vec(input int i);
    @(negedge clk);
    apply_vec(i);
    pkt_valid  = 1'b1;
    flit_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_pkt_ready", i), 64'(pkt_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      #1;
      chk_flit($sformatf("v%0d_flit%0d", i, k), vflit(i, k));
      chk($sformatf("v%0d_busy%0d", i, k), 64'(busy), 64'd1);
    end
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_end_valid", i), 64'(flit_valid), 64'd0);
    chk($sformatf("v%0d_end_busy", i), 64'(busy), 64'd0);
    chk($sformatf("v%0d_end_ready", i), 64'(pkt_ready), 64'd1);
    $display("[TB] vector %0d data=0x%08h done", i, vecs[i].data);
  endtask

  // Reference model: flit k of a packet, from the field layout rules.
  function automatic logic [15:0] model_flit(input logic [31:0] d, input logic [3:0] dest,
                                             input logic [3:0] src, input logic [2:0] mode,
                                             input logic [1:0] flag, input int k);
    logic [63:0] t;
    if (k == 0) begin
      t = (64'd4 << 13) | (64'(flag) << 11) | (64'(mode) << 8) | (64'(dest) << 4) | 64'(src);
    end else begin
      t = (64'(d) >> (15 * (k - 1))) & 64'h7FFF;
      t = (t << 1) | ((k == 3) ? 64'd1 : 64'd0);
    end
    return t[15:0];
  endfunction

  // One cycle of the randomized phase: inputs are already driven.
  task automatic sb_cycle();
    #1;
    if (hold) begin
      chk("hold_valid", 64'(flit_valid), 64'd1);
      chk("hold_flit", 64'(flit), 64'(held));
    end
    if (flit_valid && flit_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rand_extra_flit: got 0x%0h required none", flit);
      end else begin
        logic [15:0] e;
        e = sbq.pop_front();
        chk("rand_flit", 64'(flit), 64'(e));
`ifdef NI_FLIT_PARITY_EN
        chk("rand_par", 64'(par), 64'(^e));
`endif
      end
    end
    hold = flit_valid && !flit_ready;
    held = flit;
    if (pkt_valid && pkt_ready) begin
      for (int k = 0; k < 4; k++)
        sbq.push_back(model_flit(pkt_data, pkt_dest, pkt_src, pkt_mode, pkt_flag, k));
      $display("[TB] rand accept data=0x%08h dest=%0h src=%0h", pkt_data, pkt_dest, pkt_src);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e8;

    vecs[0] = '{32'hDEADBEEF, 4'h5, 4'hA, 3'b010, 2'b01, 64'h8A5A_7DDE_7AB6_0007};
    vecs[1] = '{32'h00000001, 4'h5, 4'hA, 3'b010, 2'b01, 64'h8A5A_0002_0000_0001};
    vecs[2] = '{32'h00000000, 4'h0, 4'h0, 3'b000, 2'b00, 64'h8000_0000_0000_0001};
    vecs[3] = '{32'hFFFFFFFF, 4'hF, 4'hF, 3'b111, 2'b11, 64'h9FFF_FFFE_FFFE_0007};

    rst        = 1'b1;
    pkt_valid  = 1'b0;
    flit_ready = 1'b0;
    p8_valid   = 1'b0;
    p8_data    = 8'h00;
    f8_ready   = 1'b1;
    hold       = 1'b0;
    held       = 16'h0;
    apply_vec(0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit", 64'(flit), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_ready", 64'(pkt_ready), 64'd1);
`ifdef NI_FLIT_PARITY_EN
    chk("rst_par", 64'(par), 64'd0);
`endif
    $display("[TB] reset checked");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven packets
    for (int i = 0; i < 4; i++) run_vec(i);

    // Backpressure during the first body flit
    @(negedge clk);
    apply_vec(0);
    pkt_valid  = 1'b1;
    flit_ready = 1'b1;
    #1;
    @(negedge clk);
    pkt_valid = 1'b0;
    #1;
    chk_flit("bp_head", 16'h8A5A);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      flit_ready = 1'b0;
      #1;
      chk_flit($sformatf("bp_hold%0d", c), 16'h7DDE);
    end
    @(negedge clk);
    flit_ready = 1'b1;
    #1;
    chk_flit("bp_release", 16'h7DDE);
    @(negedge clk);
    #1;
    chk_flit("bp_body1", 16'h7AB6);
    @(negedge clk);
    #1;
    chk_flit("bp_tail", 16'h0007);
    @(negedge clk);
    #1;
    chk("bp_end_valid", 64'(flit_valid), 64'd0);
    $display("[TB] backpressure sequence done");

    // Back-to-back packets
    @(negedge clk);
    apply_vec(0);
    pkt_valid = 1'b1;
    #1;
    @(negedge clk);
    pkt_valid = 1'b0;
    #1;
    chk_flit("b2b_head0", 16'h8A5A);
    chk("b2b_ready_head", 64'(pkt_ready), 64'd0);
    @(negedge clk);
    #1;
    chk_flit("b2b_body0", 16'h7DDE);
    chk("b2b_ready_body", 64'(pkt_ready), 64'd0);
    @(negedge clk);
    #1;
    chk_flit("b2b_body1", 16'h7AB6);
    @(negedge clk);
    apply_vec(1);
    pkt_valid  = 1'b1;
    flit_ready = 1'b0;
    #1;
    chk_flit("b2b_tail_stall", 16'h0007);
    chk("b2b_ready_stall", 64'(pkt_ready), 64'd0);
    @(negedge clk);
    flit_ready = 1'b1;
    #1;
    chk_flit("b2b_tail", 16'h0007);
    chk("b2b_ready_tail", 64'(pkt_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      #1;
      chk_flit($sformatf("b2b_second%0d", k), vflit(1, k));
    end
    @(negedge clk);
    #1;
    chk("b2b_end_busy", 64'(busy), 64'd0);
    $display("[TB] back-to-back sequence done");

    // Reset in the middle of a packet
    @(negedge clk);
    apply_vec(0);
    pkt_valid = 1'b1;
    #1;
    @(negedge clk);
    pkt_valid = 1'b0;
    #1;
    chk_flit("mid_head", 16'h8A5A);
    @(negedge clk);
    #1;
    chk_flit("mid_body0", 16'h7DDE);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(flit_valid), 64'd0);
    chk("mid_rst_ready", 64'(pkt_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] mid-packet reset applied");
    run_vec(0);

    // Single data flit configuration
    @(negedge clk);
    apply_vec(0);
    p8_valid = 1'b1;
    p8_data  = 8'hFF;
    #1;
    chk("d8_ready", 64'(p8_ready), 64'd1);
    @(negedge clk);
    p8_valid = 1'b0;
    #1;
    e8 = 16'h4A5A;
    chk("d8_head_valid", 64'(f8_valid), 64'd1);
    chk("d8_head", 64'(f8), 64'(e8));
    chk("d8_head_cnt", 64'(f8[15:13]), 64'd2);
`ifdef NI_FLIT_PARITY_EN
    chk("d8_head_par", 64'(par8), 64'(^e8));
`endif
    @(negedge clk);
    #1;
    e8 = 16'h01FF;
    chk("d8_tail_valid", 64'(f8_valid), 64'd1);
    chk("d8_tail", 64'(f8), 64'(e8));
`ifdef NI_FLIT_PARITY_EN
    chk("d8_tail_par", 64'(par8), 64'(^e8));
`endif
    @(negedge clk);
    #1;
    chk("d8_end_valid", 64'(f8_valid), 64'd0);
    chk("d8_end_busy", 64'(busy8), 64'd0);
    $display("[TB] single data flit sequence done");

    // Randomized traffic against the reference model
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      pkt_valid  = ($urandom_range(0, 1) == 1);
      pkt_data   = $urandom;
      pkt_dest   = 4'($urandom_range(0, 15));
      pkt_src    = 4'($urandom_range(0, 15));
      pkt_mode   = 3'($urandom_range(0, 7));
      pkt_flag   = 2'($urandom_range(0, 3));
      flit_ready = ($urandom_range(0, 9) < 7);
      sb_cycle();
    end
    for (int c = 0; c < 50; c++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      pkt_valid  = 1'b0;
      flit_ready = 1'b1;
      sb_cycle();
    end
    chk("rand_drain", 64'(sbq.size()), 64'd0);
    @(negedge clk);
    #1;
    chk("rand_end_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
